seq_pack: RTL and testbench
===========================

# seq_pack

Downstream stage of the sequence detector. Packs the detector's 1-bit per-cycle result stream into 8-bit words with hit counts, and flushes a partial word at end of frame. Buffers the words in a small FIFO and presents them on a valid/ready output port. The port feeds the result-collection logic.

## Interface
- WORD_W, 8, bits per packed word; LSB is the earliest result.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a detector result is present this cycle; the high run is one frame.
- in_data  input  1  detector result bit (1 = increasing triple found).
- out_ready  input  1  consumer accepts the head word this cycle.
- out_valid  output  1  head word available.
- out_data  output  WORD_W  packed result bits, zero-padded above out_len.
- out_len  output  4  number of valid bits in out_data, 1..WORD_W.
- out_hits  output  4  count of 1s in out_data.
- overflow  output  1  sticky; a word was dropped because the FIFO was full.

## Operation
- Accumulator: shift register acc, bit counter bit_cnt (0..WORD_W-1), hit counter hit_cnt, and in_valid_d (in_valid delayed one cycle).
- Edge with in_valid=1:
  - in_data is written to acc[bit_cnt], and hit_cnt increments by in_data.
  - If bit_cnt == WORD_W-1, a push request is raised for {acc with new bit, WORD_W, hit_cnt+in_data}.
  - acc, bit_cnt and hit_cnt then clear for the next word.
- Frame end is an edge with in_valid=0 and in_valid_d=1:
  - If bit_cnt != 0, a push request is raised for {acc zero-padded, bit_cnt, hit_cnt}, then the accumulator clears.
  - If bit_cnt == 0, nothing is pushed.
- Pop: occurs on an edge with out_valid && out_ready.
- Push acceptance:
  - A push is accepted when count < DEPTH, or when a pop occurs on the same edge.
  - Otherwise the word is discarded and overflow sets to 1; only reset clears it.
  - The accumulator clears regardless of acceptance.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Output stage:
  - out_valid = (count != 0).
  - out_data, out_len and out_hits show the FIFO head.
  - They hold stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- in_data is ignored while in_valid=0.

## Timing
- Reset values: out_valid 0, out_data 0, out_len 0, out_hits 0, overflow 0; acc, counters, pointers and in_valid_d are 0.
- Reset is asynchronous. Assertion mid-frame discards the partial word and all FIFO contents; no flush occurs after release.
- Latency:
  - out_valid rises right after the edge that samples the WORD_W-th bit.
  - For a partial word, out_valid rises right after the frame-end edge.
  - Both cases assume the FIFO was empty.
- Throughput is one word pop per cycle.
- A one-cycle in_valid gap both ends the current frame and lets a new frame start on the next cycle. The flush and the first bit of the new frame never collide.
- Full word completion and frame end cannot occur on the same edge, so at most one push per edge.

## Structure
- Package seq_pack_pkg holds:
  - WORD_W and LEN_W=4.
  - Typedef word_t: struct packed {logic [WORD_W-1:0] data; logic [3:0] len; logic [3:0] hits;}.
- Sub-module seq_pack_fifo: a DEPTH×word_t synchronous FIFO.
  - Inputs: push, push_data, pop.
  - Outputs: head, count, full, empty.
  - Asynchronous active-low reset.
- The top level holds the accumulator, frame-end detection and overflow flag.

## Test plan
- Full word: frame of bits 1,0,1,1,0,0,0,1 with out_ready=1.
  - One beat: out_data=0x8D, out_len=8, out_hits=4.
  - out_valid is high exactly one cycle, right after the 8th edge.
- Partial flush: frame of bits 1,1,0 then in_valid=0.
  - One beat: out_data=0x03, out_len=3, out_hits=2, after the frame-end edge.
- Boundary frame end: frame of 8 bits all 1, then idle.
  - Exactly one word (0xFF, len 8, hits 8); no empty flush word.
- Backpressure and overflow: out_ready=0, feed 5 full words of 0xAA pattern.
  - count saturates at 4 and overflow=1 after the 5th completion.
  - Then out_ready=1 gives 4 beats of 0xAA, len 8, hits 4, with data stable during the stall.
- Push with pop when full: FIFO full, out_ready=1 on the edge completing a new word.
  - The word is accepted, overflow stays 0, count stays 4.
- Reset mid-frame: after 5 bits, pulse rst_n low.
  - All outputs go to 0 immediately.
  - No flush word appears; a following 8-bit frame packs from bit 0.

Source files
------------

// File: rtl/seq_pack_pkg.sv
// Shared widths and the packed word record used by the result packer and its FIFO.
// A word carries up to WORD_W detector bits, how many of them are valid, and how many are 1.
package seq_pack_pkg;
   localparam int WORD_W = 8;
   localparam int LEN_W  = 4;
   localparam int BIT_W  = $clog2(WORD_W);

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [LEN_W-1:0]  len;
      logic [LEN_W-1:0]  hits;
   } word_t;
endpackage

// File: rtl/seq_pack_fifo.sv
// DEPTH x word_t synchronous FIFO; head is visible combinationally, push/pop take effect on the edge.
// Push on full is ignored unless a pop happens on the same edge; pop on empty is ignored.
module seq_pack_fifo
   import seq_pack_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push,
   input  word_t          push_data,
   input  logic           pop,
   output word_t          head,
   output logic [PTR_W:0] count,
   output logic           full,
   output logic           empty
);

   word_t              r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W:0]     r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == (PTR_W+1)'(DEPTH));
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);
   assign head      = r_mem[r_rd_ptr];
   assign count     = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + (PTR_W+1)'(w_do_push) - (PTR_W+1)'(w_do_pop);
      end
   end

   // Storage needs no reset: nothing reads an entry before it has been written.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

// File: rtl/seq_pack.sv
// Packs the 1-bit detector stream into WORD_W-bit words with hit counts, flushing partial words at frame end.
// Word visible the cycle after its last bit (or frame end); stalls hold the head, a push into a full FIFO is dropped and sets overflow.
module seq_pack
   import seq_pack_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_data,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   output logic [LEN_W-1:0]  out_len,
   output logic [LEN_W-1:0]  out_hits,
   output logic              overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WORD_W-1:0] r_acc;
   logic [BIT_W-1:0]  r_bit_cnt;
   logic [LEN_W-1:0]  r_hit_cnt;
   logic              r_in_valid_d;
   logic              r_overflow;

   logic [WORD_W-1:0] w_acc_new;
   logic [LEN_W-1:0]  w_hit_new;
   logic              w_word_done;
   logic              w_push;
   logic              w_pop;
   logic              w_accept;
   word_t             w_push_word;
   word_t             w_head;
   logic [PTR_W:0]    w_count;
   logic              w_full;
   logic              w_empty;

   assign w_word_done = in_valid && (r_bit_cnt == BIT_W'(WORD_W-1));
   assign w_pop       = out_valid && out_ready;
   assign w_accept    = !w_full || w_pop;

   always_comb begin
      w_acc_new            = r_acc;
      w_acc_new[r_bit_cnt] = in_data;
      w_hit_new            = r_hit_cnt + LEN_W'(in_data);
      w_push               = 1'b0;
      w_push_word          = '0;
      if (w_word_done) begin
         w_push      = 1'b1;
         w_push_word = '{data: w_acc_new, len: LEN_W'(WORD_W), hits: w_hit_new};
      end else if (!in_valid && r_in_valid_d && (r_bit_cnt != '0)) begin
         // Frame end: bits above bit_cnt are still zero from the last clear.
         w_push      = 1'b1;
         w_push_word = '{data: r_acc, len: LEN_W'(r_bit_cnt), hits: r_hit_cnt};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc        <= '0;
         r_bit_cnt    <= '0;
         r_hit_cnt    <= '0;
         r_in_valid_d <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_in_valid_d <= in_valid;
         if (w_push && !w_accept) r_overflow <= 1'b1;
         if (in_valid && !w_word_done) begin
            r_acc     <= w_acc_new;
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_hit_cnt <= w_hit_new;
         end else begin
            r_acc     <= '0;
            r_bit_cnt <= '0;
            r_hit_cnt <= '0;
         end
      end
   end

   seq_pack_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_push_word),
      .pop       (w_pop),
      .head      (w_head),
      .count     (w_count),
      .full      (w_full),
      .empty     (w_empty)
   );

   assign out_valid = (w_count != '0);
   assign out_data  = w_empty ? '0 : w_head.data;
   assign out_len   = w_empty ? '0 : w_head.len;
   assign out_hits  = w_empty ? '0 : w_head.hits;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_pack.sv
// Bench for seq_pack: directed scenarios plus random traffic against a frame/queue-level model.
module tb_seq_pack;
   localparam int WW    = 8;
   localparam int DEPTH = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_data;
   logic          out_ready;
   logic          out_valid;
   logic [WW-1:0] out_data;
   logic [3:0]    out_len;
   logic [3:0]    out_hits;
   logic          overflow;

   seq_pack #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_len   (out_len),
      .out_hits  (out_hits),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WW-1:0] data;
      int            len;
      int            hits;
   } mword_t;

   mword_t mq[$];
   logic   fb[$];
   logic   m_ovf;
   int     n_checks;
   int     n_errors;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic make_word(output mword_t w);
      w.data = '0;
      w.len  = fb.size();
      w.hits = 0;
      for (int i = 0; i < fb.size(); i++) begin
         w.data[i] = fb[i];
         w.hits   += int'(fb[i]);
      end
      fb.delete();
   endtask

   task automatic model_edge(input logic v, input logic d, input logic r);
      bit     pop;
      bit     have;
      mword_t w;
      pop  = (mq.size() != 0) && r;
      have = 0;
      if (v) begin
         fb.push_back(d);
         if (fb.size() == WW) begin
            make_word(w);
            have = 1;
         end
      end else if (fb.size() != 0) begin
         make_word(w);
         have = 1;
      end
      if (pop) void'(mq.pop_front());
      if (have) begin
         if (mq.size() < DEPTH) mq.push_back(w);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic model_reset();
      mq.delete();
      fb.delete();
      m_ovf = 1'b0;
   endtask

   task automatic compare_model();
      check("m_valid", out_valid, mq.size() != 0);
      check("m_ovf", overflow, m_ovf);
      if (mq.size() != 0) begin
         check("m_data", out_data, mq[0].data);
         check("m_len", out_len, mq[0].len);
         check("m_hits", out_hits, mq[0].hits);
      end
   endtask

   task automatic cycle(input logic v, input logic d, input logic r);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      @(posedge clk);
      model_edge(v, d, r);
      #1;
      compare_model();
   endtask

   task automatic feed(input logic [WW-1:0] bits, input int n, input logic r);
      for (int i = 0; i < n; i++) cycle(1'b1, bits[i], r);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_vld"}, out_valid, 0);
      check({tag, "_dat"}, out_data, 0);
      check({tag, "_len"}, out_len, 0);
      check({tag, "_hit"}, out_hits, 0);
      check({tag, "_ovf"}, overflow, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      in_data   = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      model_reset();
      #1;
      check_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 1'b0;
      out_ready = 1'b0;
      model_reset();
      #12;
      check_zero("init");
      @(negedge clk);
      rst_n = 1'b1;

      // Full word 0x8D, popped immediately
      feed(8'h8D, 8, 1'b1);
      check("full_vld", out_valid, 1);
      check("full_dat", out_data, 8'h8D);
      check("full_len", out_len, 8);
      check("full_hit", out_hits, 4);
      cycle(1'b0, 1'b0, 1'b1);
      check("full_once", out_valid, 0);

      // Partial flush of 1,1,0
      feed(8'h03, 3, 1'b1);
      check("part_wait", out_valid, 0);
      cycle(1'b0, 1'b0, 1'b1);
      check("part_vld", out_valid, 1);
      check("part_dat", out_data, 8'h03);
      check("part_len", out_len, 3);
      check("part_hit", out_hits, 2);
      cycle(1'b0, 1'b0, 1'b1);

      // Frame ending exactly on a word boundary: no empty flush
      feed(8'hFF, 8, 1'b1);
      check("bnd_dat", out_data, 8'hFF);
      check("bnd_len", out_len, 8);
      check("bnd_hit", out_hits, 8);
      cycle(1'b0, 1'b0, 1'b1);
      check("bnd_noflush", out_valid, 0);
      cycle(1'b0, 1'b0, 1'b1);
      check("bnd_idle", out_valid, 0);

      // Backpressure: five words into a four-entry FIFO
      for (int k = 0; k < 5; k++) begin
         feed(8'hAA, 8, 1'b0);
         check("bp_ovf", overflow, k == 4);
      end
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check("bp_vld", out_valid, 1);
         check("bp_dat", out_data, 8'hAA);
         check("bp_len", out_len, 8);
         check("bp_hit", out_hits, 4);
         cycle(1'b0, 1'b0, 1'b1);
      end
      check("bp_empty", out_valid, 0);
      check("bp_sticky", overflow, 1);

      // Push with simultaneous pop while full
      do_reset();
      feed(8'h11, 8, 1'b0);
      feed(8'h22, 8, 1'b0);
      feed(8'h44, 8, 1'b0);
      feed(8'h88, 8, 1'b0);
      feed(8'hC3, 7, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      check("pp_ovf", overflow, 0);
      check("pp_head", out_data, 8'h22);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      check("pp_new_dat", out_data, 8'hC3);
      check("pp_new_hit", out_hits, 4);
      cycle(1'b0, 1'b0, 1'b1);
      check("pp_drained", out_valid, 0);

      // Reset mid-frame with a word waiting
      feed(8'h0F, 8, 1'b0);
      feed(8'h1F, 5, 1'b0);
      check("mr_pre", out_valid, 1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_zero("mr");
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      cycle(1'b0, 1'b0, 1'b1);
      check("mr_noflush", out_valid, 0);
      cycle(1'b0, 1'b0, 1'b1);
      feed(8'h5A, 8, 1'b1);
      check("mr_dat", out_data, 8'h5A);
      check("mr_len", out_len, 8);
      check("mr_hit", out_hits, 4);
      cycle(1'b0, 1'b0, 1'b1);

      // Random traffic
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         cycle($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 9) < 6);
      end
      for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
